// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - centisecond stopwatch controller with lap, pause blink and overflow hold
module stopwatch_ctrl (
    input  logic        CLK_1K,
    input  logic        FPGA_RST,
    input  logic        Start_Stop,
    input  logic        Lap,
    input  logic        Clear,
    output logic [23:0] Number,
    output logic [5:0]  Hide,
    output logic [5:0]  Dot,
    output logic        Running,
    output logic        Overflow
);

    typedef enum logic [2:0] {IDLE, RUN, PAUSE, LAP, FULL} state_t;

    localparam logic [23:0] COUNT_MAX = 24'h595999;
    localparam logic [5:0]  DOT_NORMAL = 6'b101011;

    state_t      state, state_n;
    logic        ss_q, lap_q, clr_q;
    logic        ss_e, lap_e, clr_e;
    logic [3:0]  presc, presc_n;
    logic [23:0] count, count_n;
    logic [23:0] lap_reg, lap_n;
    logic [8:0]  blink, blink_n;
    logic        ovf;
    logic [23:0] disp;
    logic [5:0]  hide_n;

    // Per-digit BCD increment; digits 3 and 5 are tens of seconds/minutes and wrap at 5.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  d;
        logic [3:0]  lim;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d   = v[4*k +: 4];
            lim = (k == 3 || k == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (d == lim) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        ss_e    = Start_Stop & ~ss_q;
        lap_e   = Lap & ~lap_q;
        clr_e   = Clear & ~clr_q;
        state_n = state;
        presc_n = presc;
        count_n = count;
        lap_n   = lap_reg;
        blink_n = 9'd0;
        ovf     = 1'b0;

        if (state == RUN || state == LAP) begin
            if (presc == 4'd9) begin
                presc_n = 4'd0;
                if (count == COUNT_MAX)
                    ovf = 1'b1;
                else
                    count_n = bcd_inc(count);
            end else begin
                presc_n = presc + 4'd1;
            end
        end

        if (state == PAUSE)
            blink_n = (blink == 9'd499) ? 9'd0 : blink + 9'd1;

        // Only the highest-priority edge that is legal in this state takes effect.
        if (clr_e && (state == IDLE || state == PAUSE || state == FULL)) begin
            state_n = IDLE;
            count_n = 24'd0;
            presc_n = 4'd0;
            lap_n   = 24'd0;
        end else if (ss_e && state != FULL) begin
            case (state)
                IDLE: begin
                    state_n = RUN;
                    presc_n = 4'd0;
                end
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                LAP:     state_n = PAUSE;
                default: state_n = state;
            endcase
        end else if (lap_e) begin
            if (state == RUN) begin
                state_n = LAP;
                lap_n   = count;
            end else if (state == LAP) begin
                state_n = RUN;
            end
        end

        if (ovf)
            state_n = FULL;

        if (state_n == PAUSE && state != PAUSE)
            blink_n = 9'd0;

        disp   = (state_n == LAP) ? lap_n : count_n;
        hide_n = {disp[23:20] == 4'd0, disp[23:16] == 8'd0, 4'b0000};
        if (state_n == PAUSE && blink_n >= 9'd250)
            hide_n = 6'b111111;
    end

    always_ff @(posedge CLK_1K or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            state    <= IDLE;
            ss_q     <= 1'b1;
            lap_q    <= 1'b1;
            clr_q    <= 1'b1;
            presc    <= 4'd0;
            count    <= 24'd0;
            lap_reg  <= 24'd0;
            blink    <= 9'd0;
            Number   <= 24'h000000;
            Hide     <= 6'b110000;
            Dot      <= DOT_NORMAL;
            Running  <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_n;
            ss_q     <= Start_Stop;
            lap_q    <= Lap;
            clr_q    <= Clear;
            presc    <= presc_n;
            count    <= count_n;
            lap_reg  <= lap_n;
            blink    <= blink_n;
            Number   <= disp;
            Hide     <= hide_n;
            Dot      <= (state_n == FULL) ? 6'b000000 : DOT_NORMAL;
            Running  <= (state_n == RUN || state_n == LAP);
            Overflow <= (state_n == FULL);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    logic        clk;
    logic        rst;
    logic        ss, lap, clr;
    logic [23:0] number;
    logic [5:0]  hide, dot;
    logic        running, overflow;

    stopwatch_ctrl dut (
        .CLK_1K     (clk),
        .FPGA_RST   (rst),
        .Start_Stop (ss),
        .Lap        (lap),
        .Clear      (clr),
        .Number     (number),
        .Hide       (hide),
        .Dot        (dot),
        .Running    (running),
        .Overflow   (overflow)
    );

    typedef struct {
        int          at;
        string       name;
        logic [23:0] num;
        logic [5:0]  hid;
        logic [5:0]  dt;
        logic        run;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int k, input string name, input logic [23:0] num,
                        input logic [5:0] hid, input logic run, input logic ovf);
        exp_t e;
        e.at   = cyc + k;
        e.name = name;
        e.num  = num;
        e.hid  = hid;
        e.dt   = ovf ? 6'b000000 : 6'b101011;
        e.run  = run;
        e.ovf  = ovf;
        q.push_back(e);
    endtask

    // Monitor: compare every expectation whose cycle has come due.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                n_vec++;
                if (q[i].at < cyc) begin
                    n_miss++;
                    $display("FAIL %s: check cycle %0d missed (now %0d)", q[i].name, q[i].at, cyc);
                end else if (number !== q[i].num || hide !== q[i].hid || dot !== q[i].dt ||
                             running !== q[i].run || overflow !== q[i].ovf) begin
                    n_miss++;
                    $display("FAIL %s @%0d: got num=%h hide=%b dot=%b run=%b ovf=%b, want num=%h hide=%b dot=%b run=%b ovf=%b",
                             q[i].name, cyc, number, hide, dot, running, overflow,
                             q[i].num, q[i].hid, q[i].dt, q[i].run, q[i].ovf);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1; ss = 1'b0; lap = 1'b0; clr = 1'b0;
        tick(2);
        push(1, "reset", 24'h000000, 6'b110000, 0, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        ss = 1'b1;
        push(1,    "ss_start",  24'h000000, 6'b110000, 1, 0);
        push(10,   "pre_inc",   24'h000000, 6'b110000, 1, 0);
        push(11,   "first_inc", 24'h000001, 6'b110000, 1, 0);
        push(1001, "run_1s",    24'h000100, 6'b110000, 1, 0);
        tick(1); ss = 1'b0; tick(1000);

        lap = 1'b1;
        push(1,   "lap_freeze", 24'h000100, 6'b110000, 1, 0);
        push(500, "lap_held",   24'h000100, 6'b110000, 1, 0);
        tick(1); lap = 1'b0; tick(499);

        lap = 1'b1;
        push(1, "lap_release", 24'h000150, 6'b110000, 1, 0);
        tick(1); lap = 1'b0;

        ss = 1'b1; lap = 1'b1; clr = 1'b1;
        push(1,   "multi_pause",  24'h000150, 6'b110000, 0, 0);
        push(250, "blink_on_end", 24'h000150, 6'b110000, 0, 0);
        push(251, "blink_off",    24'h000150, 6'b111111, 0, 0);
        push(500, "blink_off_end",24'h000150, 6'b111111, 0, 0);
        push(501, "blink_wrap",   24'h000150, 6'b110000, 0, 0);
        tick(1); ss = 1'b0; lap = 1'b0; clr = 1'b0; tick(500);

        clr = 1'b1;
        push(1, "clear_pause", 24'h000000, 6'b110000, 0, 0);
        tick(1); clr = 1'b0; tick(1);

        ss = 1'b1;
        push(59991, "carry_59_99", 24'h005999, 6'b110000, 1, 0);
        push(60001, "one_minute",  24'h010000, 6'b100000, 1, 0);
        tick(1); ss = 1'b0; tick(60000);

        ss = 1'b1;
        push(1, "pause_1min", 24'h010000, 6'b100000, 0, 0);
        tick(1); ss = 1'b0; tick(1);

        clr = 1'b1;
        push(1, "clear_1min", 24'h000000, 6'b110000, 0, 0);
        tick(1); clr = 1'b0; tick(1);

        force dut.count = 24'h595999;
        tick(3);
        release dut.count;
        push(1, "preload", 24'h595999, 6'b000000, 0, 0);
        tick(1);

        ss = 1'b1;
        push(1,  "run_at_max", 24'h595999, 6'b000000, 1, 0);
        push(10, "max_hold",   24'h595999, 6'b000000, 1, 0);
        push(11, "full",       24'h595999, 6'b000000, 0, 1);
        tick(1); ss = 1'b0; tick(10);

        ss = 1'b1;
        push(1, "ss_in_full", 24'h595999, 6'b000000, 0, 1);
        tick(1); ss = 1'b0; tick(1);

        clr = 1'b1;
        push(1, "clear_full", 24'h000000, 6'b110000, 0, 0);
        tick(1); clr = 1'b0; tick(1);

        ss = 1'b1;
        push(25, "pre_reset", 24'h000002, 6'b110000, 1, 0);
        tick(1); ss = 1'b0; tick(24);
        rst = 1'b1;
        push(1, "reset_midrun", 24'h000000, 6'b110000, 0, 0);
        tick(2);
        rst = 1'b0;
        push(30, "after_reset", 24'h000000, 6'b110000, 0, 0);
        tick(30);

        ss = 1'b1; rst = 1'b1;
        tick(2);
        rst = 1'b0;
        push(5, "held_through_reset", 24'h000000, 6'b110000, 0, 0);
        tick(5); ss = 1'b0; tick(2);
        ss = 1'b1;
        push(1, "new_press", 24'h000000, 6'b110000, 1, 0);
        tick(1); ss = 1'b0; tick(2);

        for (int w = 0; w < 100 && q.size() > 0; w++) tick(1);
        while (q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: never checked (due %0d)", q[0].name, q[0].at);
            q.delete(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have port CLK_1K  in  1  1 kHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port FPGA_RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port Start_Stop  in  1  debounced, synchronous level; acts on rising edge.
REQ-004 SHALL have port Lap  in  1  debounced, synchronous level; acts on rising edge.
REQ-005 SHALL have port Clear  in  1  debounced, synchronous level; acts on rising edge.
REQ-006 SHALL have port Number  out  24  six BCD digits, digit k = Number[4k+3:4k]: k0 centisec ones, k1 centisec tens, k2 sec ones, k3 sec tens, k4 min ones, k5 min tens.
REQ-007 SHALL have port Hide  out  6  per-digit blank, 1 = blanked.
REQ-008 SHALL have port Dot  out  6  per-digit decimal point, active-low (0 = lit).
REQ-009 SHALL have port Running  out  1  high in RUN or LAP.
REQ-010 SHALL have port Overflow  out  1  high in FULL.

Function
REQ-011 SHALL detect each input edge: a previous-sample register per input; edge = current 1 and previous 0; the state acts on the same CLK_1K edge at which the 1 is first sampled.
REQ-012 SHALL implement states IDLE, RUN, PAUSE, LAP, FULL.
REQ-013 SHALL apply Start_Stop edges as IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE; ignored in FULL.
REQ-014 SHALL apply Lap edges as RUN->LAP (lap register := live count), LAP->RUN; ignored in IDLE, PAUSE, FULL.
REQ-015 SHALL apply Clear edges in IDLE, PAUSE, FULL as ->IDLE, live count := 0, prescaler := 0, lap register := 0; ignored in RUN and LAP.
REQ-016 SHALL resolve simultaneous edges with priority Clear > Start_Stop > Lap; lower-priority edges in the same cycle are discarded.
REQ-017 SHALL run a mod-10 prescaler (0..9) only in RUN and LAP; held in PAUSE; cleared on IDLE->RUN.
REQ-018 SHALL increment the live count by 0.01 s on each cycle where the prescaler equals 9; the first increment occurs 10 cycles after IDLE->RUN.
REQ-019 SHALL count in BCD with per-digit wrap k0 9->0, k1 9->0, k2 9->0, k3 5->0, k4 9->0, k5 5->0, each carrying into the next digit.
REQ-020 SHALL detect an increment at 59:59.99: the count stays at 59:59.99 and the state becomes FULL.
REQ-021 SHALL drive Number registered, updated on the same edge as state: the lap register in LAP, otherwise the live count.
REQ-022 SHALL drive Hide with leading-zero blanking on the displayed value: bit5 = (k5==0); bit4 = (k5==0 and k4==0); bits3..0 = 0.
REQ-023 SHALL run a blink counter in PAUSE, reset to 0 on PAUSE entry and period 500 cycles: counts 0..249 apply REQ-022 Hide, counts 250..499 force Hide = 6'b111111.
REQ-024 SHALL drive Dot = 6'b101011 (points after min ones and sec ones) in all states except FULL, where Dot = 6'b000000.

Reset
REQ-025 SHALL, while FPGA_RST is high and irrespective of the clock, set state IDLE, count/lap/prescaler/blink = 0, Number = 24'h000000, Hide = 6'b110000, Dot = 6'b101011, Running = 0, Overflow = 0.
REQ-026 SHALL reset the edge-detect registers to 1, so that an input held high through reset release produces no edge.
REQ-027 SHALL, on reset asserted mid-RUN, abort the run immediately with no further count increment after release until a new Start_Stop edge.

Verification
REQ-028 SHALL cover: reset, Start_Stop edge, 1000 cycles -> Number = 24'h000100, Hide = 6'b110000, Running = 1.
REQ-029 SHALL cover: run 60000 cycles -> Number = 24'h010000, Hide = 6'b100000.
REQ-030 SHALL cover: Lap edge at count 00:01.00, 500 more cycles -> Number frozen at 24'h000100; second Lap edge -> Number = 24'h000150.
REQ-031 SHALL cover: Start_Stop, Lap, Clear same cycle in RUN -> PAUSE; Hide = 6'b110000 for 250 cycles, then 6'b111111 for 250 cycles; count held.
REQ-032 SHALL cover: preload to 59:59.99 via run, 10 more cycles -> Number = 24'h595999, Overflow = 1, Dot = 6'b000000, Start_Stop ignored; Clear -> Number = 0, Overflow = 0.
REQ-033 SHALL cover: Start_Stop held high across reset release -> stays IDLE until the input is released and pressed again.
